// File: rtl/alu_result_stage.sv
// Execute/writeback boundary register with valid/ready handshake and the architectural NVCZ flag register.
// Define ALU_RESULT_SKID_EN for a 2-entry skid buffer with registered in_ready; otherwise a single register with combinational in_ready.
module alu_result_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_R,
    input  logic [3:0]   in_flags,
    input  logic [4:0]   in_dest,
    input  logic         in_set_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_R,
    output logic [3:0]   out_flags,
    output logic [4:0]   out_dest,
    output logic [3:0]   flags_q
);

    // Payload layout: {R, flags[3:0], dest[4:0], set_flags}
    localparam int PW = N + 10;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_q, main_d;
    logic          in_xfer, out_xfer;

    assign in_pl    = {in_R, in_flags, in_dest, in_set_flags};
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    assign out_R     = main_q[PW-1:10];
    assign out_flags = main_q[9:6];
    assign out_dest  = main_q[5:1];

`ifdef ALU_RESULT_SKID_EN
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          in_ready_q;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_pl;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        skid_d  = in_pl;
                        state_d = ST_FULL;
                    end
                    2'b01: state_d = ST_EMPTY;
                    2'b11: main_d = in_pl;
                    default: ;
                endcase
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain direction can move
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end
`else
    logic main_vld_q, main_vld_d;

    assign out_valid = main_vld_q;
    assign in_ready  = ~main_vld_q | out_ready;

    always_comb begin
        main_d     = in_xfer ? in_pl : main_q;
        main_vld_d = in_xfer | (main_vld_q & ~out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld_q <= 1'b0;
            main_q     <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_q     <= main_d;
        end
    end
`endif

    // Architectural flags follow consumed results only; reset wins over a same-edge consume
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (out_xfer && main_q[0]) begin
            flags_q <= main_q[9:6];
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and random bench for alu_result_stage with a payload scoreboard queue and flag model.
module tb_alu_result_stage;

    localparam int N  = 32;
    localparam int PW = N + 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_R;
    logic [3:0]   in_flags;
    logic [4:0]   in_dest;
    logic         in_set_flags;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_R;
    logic [3:0]   out_flags;
    logic [4:0]   out_dest;
    logic [3:0]   flags_q;

    alu_result_stage #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_R         (in_R),
        .in_flags     (in_flags),
        .in_dest      (in_dest),
        .in_set_flags (in_set_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_R        (out_R),
        .out_flags    (out_flags),
        .out_dest     (out_dest),
        .flags_q      (flags_q)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [PW-1:0] sb_q[$];
    logic [3:0]    m_flags = 4'b0000;
    bit            known   = 1'b0;

`ifdef ALU_RESULT_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Checks the pre-edge outputs against the model, then advances the model across the coming edge.
    task automatic tick();
        logic [PW-1:0] head;
        logic          exp_rdy;
        logic          o_xfer;
        @(negedge clk);
        if (reset) begin
            sb_q.delete();
            m_flags = 4'b0000;
            known   = 1'b1;
        end else if (known) begin
            exp_rdy = SKID ? (sb_q.size() < 2) : (sb_q.size() == 0 || out_ready);
            chk("out_valid", {63'd0, out_valid}, {63'd0, sb_q.size() > 0});
            chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
            chk("flags_q", {60'd0, flags_q}, {60'd0, m_flags});
            o_xfer = out_ready && (sb_q.size() > 0);
            if (sb_q.size() > 0) begin
                head = sb_q[0];
                chk("out_payload", {23'd0, out_R, out_flags, out_dest},
                    {23'd0, head[PW-1:1]});
            end
            if (o_xfer) begin
                head = sb_q.pop_front();
                if (head[0]) m_flags = head[9:6];
            end
            if (in_valid && exp_rdy) sb_q.push_back({in_R, in_flags, in_dest, in_set_flags});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] r, input logic [3:0] f,
                         input logic [4:0] d, input logic s);
        in_valid = v; in_R = r; in_flags = f; in_dest = d; in_set_flags = s;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        drive(1'b0, '0, 4'h0, 5'd0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_R", {32'd0, out_R}, 64'd0);
        chk("rst_out_flags", {60'd0, out_flags}, 64'd0);
        chk("rst_out_dest", {59'd0, out_dest}, 64'd0);
        chk("rst_flags_q", {60'd0, flags_q}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Streaming at full rate
        out_ready = 1'b1;
        drive(1'b1, 32'd5, 4'h0, 5'd1, 1'b0); tick();
        chk("s1_valid", {63'd0, out_valid}, 64'd1);
        chk("s1_R", {32'd0, out_R}, 64'd5);
        chk("s1_dest", {59'd0, out_dest}, 64'd1);
        drive(1'b1, 32'd7, 4'h0, 5'd2, 1'b0); tick();
        chk("s2_R", {32'd0, out_R}, 64'd7);
        chk("s2_dest", {59'd0, out_dest}, 64'd2);
        chk("s2_in_ready", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 32'hFFFF_FFFF, 4'h0, 5'd3, 1'b0); tick();
        chk("s3_R", {32'd0, out_R}, 64'hFFFF_FFFF);
        chk("s3_dest", {59'd0, out_dest}, 64'd3);
        drive(1'b0, '0, 4'h0, 5'd0, 1'b0); tick();
        chk("s4_idle", {63'd0, out_valid}, 64'd0);

        // Stall behaviour
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 4'h0, 5'd4, 1'b0); tick();
        chk("st_A_R", {32'd0, out_R}, 64'h10);
`ifdef ALU_RESULT_SKID_EN
        drive(1'b1, 32'h20, 4'h0, 5'd5, 1'b0); tick();
        chk("st_full_rdy", {63'd0, in_ready}, 64'd0);
        chk("st_hold_R", {32'd0, out_R}, 64'h10);
        drive(1'b1, 32'hDEAD, 4'hF, 5'd9, 1'b1); tick();
        chk("st_hold2_R", {32'd0, out_R}, 64'h10);
        drive(1'b0, '0, 4'h0, 5'd0, 1'b0);
        out_ready = 1'b1; tick();
        chk("st_drain_R", {32'd0, out_R}, 64'h20);
        chk("st_drain_rdy", {63'd0, in_ready}, 64'd1);
        tick();
        chk("st_empty", {63'd0, out_valid}, 64'd0);
`else
        chk("st_rdy_low", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 32'hDEAD, 4'hF, 5'd9, 1'b1); tick();
        chk("st_hold_R", {32'd0, out_R}, 64'h10);
        drive(1'b1, 32'h20, 4'h0, 5'd5, 1'b0);
        out_ready = 1'b1; #1;
        chk("st_pass_rdy", {63'd0, in_ready}, 64'd1);
        tick();
        chk("st_pass_R", {32'd0, out_R}, 64'h20);
        drive(1'b0, '0, 4'h0, 5'd0, 1'b0); tick();
        chk("st_empty", {63'd0, out_valid}, 64'd0);
`endif

        // Flag register update rule
        out_ready = 1'b1;
        drive(1'b1, 32'd0, 4'b0001, 5'd6, 1'b1); tick();
        drive(1'b1, 32'd9, 4'b1000, 5'd7, 1'b0); tick();
        chk("fl_set", {60'd0, flags_q}, 64'b0001);
        chk("fl_out_flags", {60'd0, out_flags}, 64'b1000);
        drive(1'b0, '0, 4'h0, 5'd0, 1'b0); tick();
        chk("fl_keep", {60'd0, flags_q}, 64'b0001);

        // Reset while results are buffered and the output would be consumed
        out_ready = 1'b0;
        drive(1'b1, 32'h30, 4'b1111, 5'd8, 1'b1); tick();
        drive(1'b1, 32'h31, 4'b1111, 5'd9, 1'b1); tick();
        drive(1'b0, '0, 4'h0, 5'd0, 1'b0);
        out_ready = 1'b1; reset = 1'b1; tick();
        reset = 1'b0;
        chk("mr_valid", {63'd0, out_valid}, 64'd0);
        chk("mr_flags", {60'd0, flags_q}, 64'd0);
        tick();
        chk("mr_valid2", {63'd0, out_valid}, 64'd0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 32'($urandom), 4'($urandom), 5'($urandom),
                  1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end

        drive(1'b0, '0, 4'h0, 5'd0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 8 && sb_q.size() > 0; i++) tick();
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        chk("drain_flags", {60'd0, flags_q}, {60'd0, m_flags});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
